scope_push_sequencer: RTL and testbench

- Capture-and-drain controller feeding the VGA scope's 6-channel push port.
- Decimates a 6-bit sample stream, optionally waits for an edge trigger, and buffers a programmed number of samples in an 8-entry FIFO.
- Drains the FIFO into the scope only while the scope reports ready (vertical blank), with the one-cycle gap the push port requires.
- Sits between the host register block and the scope shift-register datapath.

---
 rtl/scope_push_sequencer_if.sv | 37 +++
 rtl/scope_push_sequencer.sv | 187 ++++++++++++++++++
 tb/tb_scope_push_sequencer.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/scope_push_sequencer_if.sv
// Purpose: signal bundle between host/scope side and the scope push sequencer.
// Latency: none, wires only.
// Backpressure: scope_ready gates pushes; start/abort are single-cycle pulses.
interface scope_push_sequencer_if #(
  parameter int DW    = 6,
  parameter int DIV_W = 16
);
  logic [DW-1:0]    sample_in;
  logic [DIV_W-1:0] cfg_div;
  logic [6:0]       cfg_count;
  logic             cfg_trig_en;
  logic [2:0]       cfg_trig_ch;
  logic             cfg_trig_fall;
  logic             start;
  logic             abort;
  logic             scope_ready;
  logic [DW-1:0]    push_data;
  logic             push_valid;
  logic             busy;
  logic             done;
  logic             overflow;
  logic [3:0]       level;

  // Host and scope side: drives samples, config, control and ready.
  modport master (
    output sample_in, cfg_div, cfg_count, cfg_trig_en, cfg_trig_ch, cfg_trig_fall,
    output start, abort, scope_ready,
    input  push_data, push_valid, busy, done, overflow, level
  );

  // Sequencer side.
  modport slave (
    input  sample_in, cfg_div, cfg_count, cfg_trig_en, cfg_trig_ch, cfg_trig_fall,
    input  start, abort, scope_ready,
    output push_data, push_valid, busy, done, overflow, level
  );
endinterface

// File: rtl/scope_push_sequencer.sv
// Purpose: decimate/trigger/capture samples into a small FIFO and drain them to the scope push port.
// Latency: all outputs registered; a captured sample reaches push_data 2 cycles after its tick at best.
// Backpressure: pops only while scope_ready and no strobe in flight; a full FIFO drops samples and sets overflow.
module scope_push_sequencer #(
  parameter int DW    = 6,
  parameter int DEPTH = 8,
  parameter int DIV_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  scope_push_sequencer_if.slave sp
);
  localparam int         AW   = $clog2(DEPTH);
  localparam logic [3:0] FULL = 4'(DEPTH);

  typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, FLUSH} state_t;
  state_t state, state_nx;

  // Latched run configuration
  logic [DIV_W-1:0] div_r;
  logic [6:0]       cnt_r;
  logic             trig_on_r, fall_r;
  logic [2:0]       ch_r;

  // Run progress and trigger edge history
  logic [DIV_W-1:0] div_cnt;
  logic [6:0]       smp_cnt;
  logic             hist_vld, hist_bit;

  // FIFO
  logic [DW-1:0]    mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [3:0]       level_r;

  // Registered outputs
  logic [DW-1:0]    push_data_r;
  logic             push_valid_r, done_r, overflow_r;

  // Per-cycle strobes
  logic             arm, kill, finish, tick, pop, wr, drop;
  logic             pop_ok, trig_cur, trig_hit;
  logic [7:0]       samp_ext;

  assign samp_ext = 8'(sp.sample_in);
  assign trig_cur = samp_ext[ch_r];
  assign trig_hit = hist_vld && (hist_bit != trig_cur) && (trig_cur == !fall_r);
  assign pop_ok   = sp.scope_ready && (level_r != 4'd0) && !push_valid_r;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next state and per-cycle strobes; abort overrides everything in a busy state.
  always_comb begin
    state_nx = state;
    arm      = 1'b0;
    kill     = 1'b0;
    finish   = 1'b0;
    tick     = 1'b0;
    pop      = 1'b0;
    wr       = 1'b0;
    drop     = 1'b0;
    case (state)
      IDLE: begin
        if (sp.start && !sp.abort) begin
          state_nx = ARMED;
          arm      = 1'b1;
        end
      end
      ARMED: begin
        if (!trig_on_r || trig_hit) state_nx = CAPTURE;
      end
      CAPTURE: begin
        pop = pop_ok;
        if (div_cnt == div_r) begin
          tick = 1'b1;
          wr   = (level_r != FULL) || pop;
          drop = !wr;
          if (smp_cnt == cnt_r - 7'd1) state_nx = FLUSH;
        end
      end
      FLUSH: begin
        pop = pop_ok;
        if (level_r == 4'd0 && !push_valid_r) begin
          state_nx = IDLE;
          finish   = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
    if (sp.abort && state != IDLE) begin
      state_nx = IDLE;
      kill     = 1'b1;
      finish   = 1'b0;
      tick     = 1'b0;
      pop      = 1'b0;
      wr       = 1'b0;
      drop     = 1'b0;
    end
  end

  // Latch config on arming; run the divider and sample counter; track the trigger channel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_r     <= '0;
      cnt_r     <= '0;
      trig_on_r <= 1'b0;
      fall_r    <= 1'b0;
      ch_r      <= '0;
      div_cnt   <= '0;
      smp_cnt   <= '0;
      hist_vld  <= 1'b0;
      hist_bit  <= 1'b0;
    end else if (arm) begin
      div_r     <= sp.cfg_div;
      cnt_r     <= (sp.cfg_count == 7'd0 || sp.cfg_count > 7'd64) ? 7'd64 : sp.cfg_count;
      trig_on_r <= sp.cfg_trig_en && (32'(sp.cfg_trig_ch) < DW);
      fall_r    <= sp.cfg_trig_fall;
      ch_r      <= sp.cfg_trig_ch;
      div_cnt   <= '0;
      smp_cnt   <= '0;
      hist_vld  <= 1'b0;
      hist_bit  <= 1'b0;
    end else begin
      if (state == ARMED) begin
        hist_bit <= trig_cur;
        hist_vld <= 1'b1;
      end
      if (state == CAPTURE) begin
        if (tick) begin
          div_cnt <= '0;
          smp_cnt <= smp_cnt + 7'd1;
        end else begin
          div_cnt <= div_cnt + DIV_W'(1);
        end
      end
    end
  end

  // Sample storage; contents need no reset because occupancy lives in level_r.
  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr] <= sp.sample_in;
  end

  // FIFO pointers and occupancy; emptied when a run is armed or aborted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_r <= '0;
    end else if (arm || kill) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_r <= '0;
    end else begin
      if (wr)  wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      if (wr && !pop)      level_r <= level_r + 4'd1;
      else if (pop && !wr) level_r <= level_r - 4'd1;
    end
  end

  // Push strobe, held push data, completion pulse and sticky overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      push_data_r  <= '0;
      push_valid_r <= 1'b0;
      done_r       <= 1'b0;
      overflow_r   <= 1'b0;
    end else begin
      push_valid_r <= pop;
      if (pop) push_data_r <= mem[rd_ptr];
      done_r <= finish;
      if (arm)       overflow_r <= 1'b0;
      else if (drop) overflow_r <= 1'b1;
    end
  end

  assign sp.push_data  = push_data_r;
  assign sp.push_valid = push_valid_r;
  assign sp.busy       = (state != IDLE);
  assign sp.done       = done_r;
  assign sp.overflow   = overflow_r;
  assign sp.level      = level_r;
endmodule

// File: tb/tb_scope_push_sequencer.sv
// Purpose: self-checking bench for scope_push_sequencer (vector table, corner sequences, random vs. model).
// Latency: compares every output one time unit after each rising edge.
// Backpressure: scope_ready driven per test; random phase toggles it freely.
module tb_scope_push_sequencer;
  localparam int DW    = 6;
  localparam int DEPTH = 8;
  localparam int M_IDLE = 0, M_WAIT = 1, M_CAP = 2, M_DRAIN = 3;

  logic clk, rst;
  scope_push_sequencer_if #(.DW(DW), .DIV_W(16)) bus ();
  scope_push_sequencer #(.DW(DW), .DEPTH(DEPTH), .DIV_W(16)) dut (.clk(clk), .rst(rst), .sp(bus));

  int tests, fails;

  // Reference model: a queue for the FIFO and plain counters for run progress.
  int         m_mode, m_div, m_cnt, m_cyc, m_taken;
  bit         m_trig, m_fall, m_seen, m_prev, m_pv, m_done, m_ovf;
  logic [2:0] m_ch;
  logic [5:0] m_pd;
  logic [5:0] fq[$];

  typedef struct {
    int         div;
    int         count;
    bit         trig_en;
    logic [2:0] ch;
    int         rdy_delay;
    int         exp_pushes;
    bit         exp_ovf;
    logic [5:0] exp_first;
    logic [5:0] exp_last;
  } vec_t;
  vec_t vecs[7];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = M_IDLE; m_div = 0; m_cnt = 0; m_cyc = 0; m_taken = 0;
    m_trig = 0; m_fall = 0; m_seen = 0; m_prev = 0; m_pv = 0; m_done = 0; m_ovf = 0;
    m_ch = '0; m_pd = '0;
    fq.delete();
  endtask

  task automatic model_step();
    bit pv_before, do_pop, is_tick, cur;
    int c;
    pv_before = m_pv;
    m_done = 0;
    m_pv = 0;
    if (m_mode != M_IDLE && bus.abort) begin
      m_mode = M_IDLE;
      fq.delete();
      return;
    end
    case (m_mode)
      M_IDLE: if (bus.start && !bus.abort) begin
        m_mode  = M_WAIT;
        fq.delete();
        m_ovf   = 0;
        m_div   = int'(bus.cfg_div);
        c       = int'(bus.cfg_count);
        m_cnt   = (c == 0 || c > 64) ? 64 : c;
        m_trig  = bus.cfg_trig_en && (bus.cfg_trig_ch < 3'd6);
        m_ch    = bus.cfg_trig_ch;
        m_fall  = bus.cfg_trig_fall;
        m_seen  = 0;
        m_cyc   = 0;
        m_taken = 0;
      end
      M_WAIT: begin
        cur = (m_ch < 3'd6) ? bus.sample_in[m_ch] : 1'b0;
        if (!m_trig) m_mode = M_CAP;
        else if (m_seen && cur != m_prev && cur == !m_fall) m_mode = M_CAP;
        m_prev = cur;
        m_seen = 1;
      end
      default: begin
        do_pop = bus.scope_ready && fq.size() > 0 && !pv_before;
        if (m_mode == M_DRAIN && fq.size() == 0 && !pv_before) begin
          m_mode = M_IDLE;
          m_done = 1;
        end
        if (do_pop) begin
          m_pd = fq.pop_front();
          m_pv = 1;
        end
        if (m_mode == M_CAP) begin
          is_tick = ((m_cyc + 1) % (m_div + 1)) == 0;
          m_cyc++;
          if (is_tick) begin
            if (fq.size() < DEPTH) fq.push_back(bus.sample_in);
            else m_ovf = 1;
            m_taken++;
            if (m_taken == m_cnt) m_mode = M_DRAIN;
          end
        end
      end
    endcase
  endtask

  function automatic logic [31:0] dut_vec();
    return 32'({bus.push_data, bus.push_valid, bus.busy, bus.done, bus.overflow, bus.level});
  endfunction

  function automatic logic [31:0] exp_vec();
    return 32'({m_pd, m_pv, m_mode != M_IDLE, m_done, m_ovf, 4'(fq.size())});
  endfunction

  task automatic clk_step();
    @(posedge clk);
    model_step();
    #1;
    check("cycle", dut_vec(), exp_vec());
    @(negedge clk);
  endtask

  task automatic drive(input logic [5:0] s, input bit st, input bit ab, input bit rdy);
    bus.sample_in   = s;
    bus.start       = st;
    bus.abort       = ab;
    bus.scope_ready = rdy;
  endtask

  task automatic set_cfg(input int div, input int count, input bit en, input logic [2:0] ch, input bit fall);
    bus.cfg_div       = 16'(div);
    bus.cfg_count     = 7'(count);
    bus.cfg_trig_en   = en;
    bus.cfg_trig_ch   = ch;
    bus.cfg_trig_fall = fall;
  endtask

  // One-sample run with a shaped trigger channel; reports the cycle of the first strobe.
  task automatic trig_run(input string nm, input logic [2:0] ch, input bit fall, input bit init,
                          input int ta, input int tb, input int exp_cyc);
    int first;
    bit b;
    logic [5:0] s;
    set_cfg(0, 1, 1'b1, ch, fall);
    first = -1;
    for (int k = 0; k < 40; k++) begin
      b = (k < ta) ? init : (k < tb) ? !init : init;
      s = 6'(k);
      if (ch < 3'd6) s[ch] = b;
      drive(s, k == 0, 1'b0, 1'b1);
      clk_step();
      if (bus.push_valid && first < 0) first = k + 1;
      if (!bus.busy) break;
    end
    check(nm, 32'(first), 32'(exp_cyc));
  endtask

  initial begin
    int pushes, dones, quiet;
    bit got_first;
    logic [5:0] first_d, last_d;

    rst = 1'b1;
    drive(6'd0, 1'b0, 1'b0, 1'b0);
    set_cfg(0, 0, 1'b0, 3'd0, 1'b0);
    model_reset();
    #2;
    check("reset_state", dut_vec(), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // div, count, trig_en, ch, ready delay, pushes, overflow, first data, last data
    vecs[0] = '{3, 4,   1'b0, 3'd0, 0,  4,  1'b0, 6'd5, 6'd17};
    vecs[1] = '{0, 12,  1'b0, 3'd0, 30, 8,  1'b1, 6'd2, 6'd9};
    vecs[2] = '{0, 12,  1'b0, 3'd0, 0,  12, 1'b0, 6'd2, 6'd13};
    vecs[3] = '{0, 20,  1'b0, 3'd0, 0,  18, 1'b1, 6'd2, 6'd21};
    vecs[4] = '{1, 0,   1'b0, 3'd0, 0,  64, 1'b0, 6'd3, 6'd1};
    vecs[5] = '{1, 100, 1'b0, 3'd0, 0,  64, 1'b0, 6'd3, 6'd1};
    vecs[6] = '{2, 5,   1'b1, 3'd7, 0,  5,  1'b0, 6'd4, 6'd16};

    for (int v = 0; v < 7; v++) begin
      set_cfg(vecs[v].div, vecs[v].count, vecs[v].trig_en, vecs[v].ch, 1'b0);
      pushes = 0; dones = 0; got_first = 0; first_d = '0; last_d = '0;
      for (int k = 0; k < 400 && dones == 0; k++) begin
        drive(6'(k), k == 0, 1'b0, k >= vecs[v].rdy_delay);
        clk_step();
        if (bus.push_valid) begin
          if (!got_first) first_d = bus.push_data;
          got_first = 1;
          last_d = bus.push_data;
          pushes++;
        end
        if (bus.done) dones++;
      end
      check("vec_pushes", 32'(pushes), 32'(vecs[v].exp_pushes));
      check("vec_overflow", 32'(bus.overflow), 32'(vecs[v].exp_ovf));
      check("vec_first", 32'(first_d), 32'(vecs[v].exp_first));
      check("vec_last", 32'(last_d), 32'(vecs[v].exp_last));
      check("vec_done", 32'(dones), 32'd1);
      check("vec_idle", 32'(bus.busy), 32'd0);
      drive(6'd0, 1'b0, 1'b0, 1'b1);
      clk_step();
    end

    trig_run("trig_rise", 3'd2, 1'b0, 1'b1, 5, 10, 13);
    trig_run("trig_fall", 3'd5, 1'b1, 1'b0, 4, 8, 11);
    trig_run("trig_ch7",  3'd7, 1'b0, 1'b0, 2, 3, 4);

    // Abort with three samples buffered.
    set_cfg(0, 12, 1'b0, 3'd0, 1'b0);
    for (int k = 0; k < 5; k++) begin drive(6'(k), k == 0, 1'b0, 1'b0); clk_step(); end
    check("abort_level", 32'(bus.level), 32'd3);
    drive(6'd5, 1'b0, 1'b1, 1'b0);
    clk_step();
    check("abort_idle", 32'({bus.busy, bus.level}), 32'd0);
    quiet = 0;
    for (int k = 0; k < 6; k++) begin
      drive(6'(k), 1'b0, 1'b0, 1'b1);
      clk_step();
      if (bus.push_valid || bus.done) quiet++;
    end
    check("abort_quiet", 32'(quiet), 32'd0);

    // Overflow survives an abort and is cleared by the next start.
    for (int k = 0; k < 12; k++) begin drive(6'(k), k == 0, 1'b0, 1'b0); clk_step(); end
    check("ovf_before_abort", 32'(bus.overflow), 32'd1);
    drive(6'd12, 1'b0, 1'b1, 1'b0);
    clk_step();
    check("abort_keeps_ovf", 32'({bus.busy, bus.overflow}), 32'b01);
    set_cfg(3, 2, 1'b0, 3'd0, 1'b0);
    drive(6'd0, 1'b1, 1'b0, 1'b1);
    clk_step();
    check("arm_clears_ovf", 32'({bus.busy, bus.overflow}), 32'b10);
    dones = 0;
    for (int k = 1; k < 60 && dones == 0; k++) begin
      drive(6'(k), 1'b0, 1'b0, 1'b1);
      clk_step();
      if (bus.done) dones++;
    end
    check("rerun_done", 32'(dones), 32'd1);

    // Asynchronous reset while flushing with a strobe in flight.
    set_cfg(0, 6, 1'b0, 3'd0, 1'b0);
    for (int k = 0; k < 11; k++) begin
      drive(6'(k) ^ 6'h2a, k == 0, 1'b0, k == 10);
      clk_step();
    end
    check("pre_reset", 32'({bus.push_valid, bus.busy, bus.level}), 32'({1'b1, 1'b1, 4'd5}));
    bus.scope_ready = 1'b0;
    rst = 1'b1;
    #1;
    check("async_reset", dut_vec(), 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      set_cfg($urandom_range(0, 3), $urandom_range(0, 127), $urandom_range(0, 1) == 1,
              3'($urandom_range(0, 7)), $urandom_range(0, 1) == 1);
      drive(6'($urandom), $urandom_range(0, 15) == 0, $urandom_range(0, 149) == 0,
            $urandom_range(0, 3) != 0);
      clk_step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
endmodule
